// File: rtl/text_write_sched_if.sv
// Bus bundle for the text RAM write scheduler: host port, fill engine control,
// RAM write port and the scroll double-buffer.
interface text_write_sched_if #(
    parameter int AW = 15,
    parameter int LW = 16,
    parameter int SW = 7
);
    logic          host_valid;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_data;
    logic          host_ready;

    logic          fill_start;
    logic [AW-1:0] fill_base;
    logic [LW-1:0] fill_len;
    logic [7:0]    fill_even;
    logic [7:0]    fill_odd;
    logic          fill_busy;
    logic          fill_done;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_d;

    logic          scroll_wr;
    logic [SW-1:0] scroll_in;
    logic          vblank;
    logic [SW-1:0] scroll_out;
    logic          scroll_pend;

    modport master (
        output host_valid, host_addr, host_data,
        input  host_ready,
        output fill_start, fill_base, fill_len, fill_even, fill_odd,
        input  fill_busy, fill_done,
        input  ram_we, ram_addr, ram_d,
        output scroll_wr, scroll_in, vblank,
        input  scroll_out, scroll_pend
    );

    modport slave (
        input  host_valid, host_addr, host_data,
        output host_ready,
        input  fill_start, fill_base, fill_len, fill_even, fill_odd,
        output fill_busy, fill_done,
        output ram_we, ram_addr, ram_d,
        input  scroll_wr, scroll_in, vblank,
        output scroll_out, scroll_pend
    );
endinterface

// File: rtl/text_write_sched.sv
// Single write port owner for the char/attr text RAM: host/fill arbitration with
// strict alternation under contention, plus a vblank-synchronised scroll register.
module text_write_sched #(
    parameter int AW = 15,
    parameter int LW = 16,
    parameter int SW = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    text_write_sched_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic       G_HOST = 1'b0;
    localparam logic       G_FILL = 1'b1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] faddr_q, faddr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [7:0]    even_q, even_d, odd_q, odd_d;
    logic          lgrant_q, lgrant_d;
    logic          done_q, done_d;
    logic          we_q, we_d;
    wr_t           wr_q, wr_d;
    logic [SW-1:0] pend_val_q, pend_val_d;
    logic          pend_q, pend_d;
    logic [SW-1:0] scroll_q, scroll_d;

    logic fill_req, host_ready, grant_host, grant_fill;

    always_comb begin
        fill_req   = (state_q == S_RUN);
        // Gated by rst_n so the host sees no ready while the block is held in reset.
        host_ready = rst_n && (!fill_req || lgrant_q == G_FILL);
        grant_host = bus.host_valid && host_ready;
        grant_fill = fill_req && !grant_host;

        state_d  = state_q;
        faddr_d  = faddr_q;
        rem_d    = rem_q;
        even_d   = even_q;
        odd_d    = odd_q;
        lgrant_d = lgrant_q;
        done_d   = 1'b0;
        we_d     = 1'b0;
        wr_d     = wr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.fill_start) begin
                    faddr_d = bus.fill_base;
                    rem_d   = bus.fill_len;
                    even_d  = bus.fill_even;
                    odd_d   = bus.fill_odd;
                    if (bus.fill_len != '0) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (grant_fill) begin
                    faddr_d = faddr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == LW'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (grant_host) begin
            we_d      = 1'b1;
            wr_d.addr = bus.host_addr;
            wr_d.data = bus.host_data;
            lgrant_d  = G_HOST;
        end else if (grant_fill) begin
            we_d      = 1'b1;
            wr_d.addr = faddr_q;
            wr_d.data = faddr_q[0] ? odd_q : even_q;
            lgrant_d  = G_FILL;
        end
    end

    always_comb begin
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        scroll_d   = scroll_q;
        if (bus.scroll_wr) begin
            pend_val_d = bus.scroll_in;
            pend_d     = 1'b1;
        end
        // A write coincident with vblank bypasses the pending register.
        if (bus.vblank) begin
            if (pend_q || bus.scroll_wr)
                scroll_d = bus.scroll_wr ? bus.scroll_in : pend_val_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            faddr_q    <= '0;
            rem_q      <= '0;
            even_q     <= '0;
            odd_q      <= '0;
            lgrant_q   <= G_HOST;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            wr_q       <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            scroll_q   <= '0;
        end else begin
            state_q    <= state_d;
            faddr_q    <= faddr_d;
            rem_q      <= rem_d;
            even_q     <= even_d;
            odd_q      <= odd_d;
            lgrant_q   <= lgrant_d;
            done_q     <= done_d;
            we_q       <= we_d;
            wr_q       <= wr_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            scroll_q   <= scroll_d;
        end
    end

    assign bus.host_ready  = host_ready;
    assign bus.fill_busy   = fill_req;
    assign bus.fill_done   = done_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_addr    = wr_q.addr;
    assign bus.ram_d       = wr_q.data;
    assign bus.scroll_out  = scroll_q;
    assign bus.scroll_pend = pend_q;
endmodule
